// File: rtl/nv_nvdla_hls_shiftleftsu_pipe_pkg.sv
// Shared constants for the HLS shift-left / saturate / round pipeline.
// Holds the default data-path widths and the saturation-counter geometry,
// plus a small helper for the saturating counter increment.
package nv_nvdla_hls_pkg;

    localparam int NVDLA_HLS_IN_WIDTH    = 32;
    localparam int NVDLA_HLS_FRAC_WIDTH  = 35;
    localparam int NVDLA_HLS_OUT_WIDTH   = 49;
    localparam int NVDLA_HLS_SHIFT_WIDTH = 6;

    localparam int SAT_CNT_WIDTH = 16;
    localparam logic [SAT_CNT_WIDTH-1:0] SAT_CNT_MAX = 16'hFFFF;

    typedef logic [SAT_CNT_WIDTH-1:0] sat_cnt_t;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic sat_cnt_t sat_cnt_inc(input sat_cnt_t cnt);
        return (cnt == SAT_CNT_MAX) ? cnt : sat_cnt_t'(cnt + 1'b1);
    endfunction

endpackage

// File: rtl/nv_nvdla_hls_shiftleftsu_pipe_if.sv
// Valid/ready bus of the shift-left pipeline, including the saturation
// counter clear/readback. The design side uses "slave", the producer /
// consumer side uses "master".
interface nv_nvdla_hls_shiftleftsu_pipe_if
    import nv_nvdla_hls_pkg::*;
#(
    parameter int IN_WIDTH    = NVDLA_HLS_IN_WIDTH,
    parameter int FRAC_WIDTH  = NVDLA_HLS_FRAC_WIDTH,
    parameter int OUT_WIDTH   = NVDLA_HLS_OUT_WIDTH,
    parameter int SHIFT_WIDTH = NVDLA_HLS_SHIFT_WIDTH
) ();

    logic                   in_pvld;
    logic                   in_prdy;
    logic [IN_WIDTH-1:0]    data_in;
    logic [FRAC_WIDTH-1:0]  frac_in;
    logic [SHIFT_WIDTH-1:0] shift_num;

    logic                   out_pvld;
    logic                   out_prdy;
    logic [OUT_WIDTH-1:0]   data_out;
    logic                   out_sat;

    logic                   sat_cnt_clr;
    sat_cnt_t               sat_cnt;

    modport slave (
        input  in_pvld, data_in, frac_in, shift_num, out_prdy, sat_cnt_clr,
        output in_prdy, out_pvld, data_out, out_sat, sat_cnt
    );

    modport master (
        output in_pvld, data_in, frac_in, shift_num, out_prdy, sat_cnt_clr,
        input  in_prdy, out_pvld, data_out, out_sat, sat_cnt
    );

endinterface

// File: rtl/nv_nvdla_hls_shiftleftsu_pipe_shl_core.sv
// Combinational core of stage 1: shifts the fixed-point value
// {data_in, frac_in} left without losing bits, then splits the result into
// the low OUT_WIDTH integer bits, an overflow flag for any integer bit above
// them, and (with NVDLA_HLS_SHL_ROUND_EN) the first discarded fraction bit.
module nv_nvdla_hls_shl_core
    import nv_nvdla_hls_pkg::*;
#(
    parameter int IN_WIDTH    = NVDLA_HLS_IN_WIDTH,
    parameter int FRAC_WIDTH  = NVDLA_HLS_FRAC_WIDTH,
    parameter int OUT_WIDTH   = NVDLA_HLS_OUT_WIDTH,
    parameter int SHIFT_WIDTH = NVDLA_HLS_SHIFT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]    i_data_in,
    input  logic [FRAC_WIDTH-1:0]  i_frac_in,
    input  logic [SHIFT_WIDTH-1:0] i_shift_num,
    output logic [OUT_WIDTH-1:0]   o_trunc,
`ifdef NVDLA_HLS_SHL_ROUND_EN
    output logic                   o_rnd,
`endif
    output logic                   o_ovf
);

    // Headroom for the largest possible shift so no bit falls off the top.
    localparam int SHIFT_MAX = (1 << SHIFT_WIDTH) - 1;
    localparam int V_WIDTH   = IN_WIDTH + FRAC_WIDTH + SHIFT_MAX;
    localparam int INT_WIDTH = V_WIDTH - FRAC_WIDTH;

    logic [V_WIDTH-1:0]   w_v;
    logic [INT_WIDTH-1:0] w_int;

    assign w_v   = {{SHIFT_MAX{1'b0}}, i_data_in, i_frac_in} << i_shift_num;
    assign w_int = w_v[V_WIDTH-1:FRAC_WIDTH];

    // Only the topmost fraction bit matters (as the round bit); the rest of
    // the fraction is dropped on purpose.
`ifdef NVDLA_HLS_SHL_ROUND_EN
    assign o_rnd = w_v[FRAC_WIDTH-1];
    generate
        if (FRAC_WIDTH > 1) begin : g_frac_drop
            logic w_unused_frac;
            assign w_unused_frac = ^w_v[FRAC_WIDTH-2:0];
        end
    endgenerate
`else
    logic w_unused_frac;
    assign w_unused_frac = ^w_v[FRAC_WIDTH-1:0];
`endif

    // Integer bits at or above OUT_WIDTH can only exist when the shifted
    // integer part is wider than the result.
    generate
        if (INT_WIDTH > OUT_WIDTH) begin : g_ovf
            assign o_trunc = w_int[OUT_WIDTH-1:0];
            assign o_ovf   = |w_int[INT_WIDTH-1:OUT_WIDTH];
        end else begin : g_no_ovf
            assign o_trunc = OUT_WIDTH'(w_int);
            assign o_ovf   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/nv_nvdla_hls_shiftleftsu_pipe.sv
// Two-stage unsigned shift-left with saturation and optional half-up
// rounding, plus a saturating count of saturated beats delivered.
//   Stage 1: shift, truncate to OUT_WIDTH, capture overflow and round bit.
//   Stage 2: apply the rounding increment, saturate, register the result.
// Optional feature macro: NVDLA_HLS_SHL_ROUND_EN (half-up rounding; when
// undefined the result is truncated and the round-bit flop disappears).
module nv_nvdla_hls_shiftleftsu_pipe
    import nv_nvdla_hls_pkg::*;
#(
    parameter int IN_WIDTH    = NVDLA_HLS_IN_WIDTH,
    parameter int FRAC_WIDTH  = NVDLA_HLS_FRAC_WIDTH,
    parameter int OUT_WIDTH   = NVDLA_HLS_OUT_WIDTH,
    parameter int SHIFT_WIDTH = NVDLA_HLS_SHIFT_WIDTH
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rst,
    nv_nvdla_hls_shiftleftsu_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Handshake: each stage can take a new beat when empty or draining.
    // ------------------------------------------------------------------
    logic w_s1_rdy;
    logic w_s2_rdy;
    logic w_in_acc;
    logic w_s1_adv;
    logic w_out_hs;

    logic r_s1_vld;
    logic r_s2_vld;

    assign w_s2_rdy = ~r_s2_vld | bus.out_prdy;
    assign w_s1_rdy = ~r_s1_vld | w_s2_rdy;
    assign w_in_acc = bus.in_pvld & w_s1_rdy;
    assign w_s1_adv = r_s1_vld & w_s2_rdy;
    assign w_out_hs = r_s2_vld & bus.out_prdy;

    assign bus.in_prdy  = w_s1_rdy;
    assign bus.out_pvld = r_s2_vld;

    // ------------------------------------------------------------------
    // Stage 1: shifter core and its registers.
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] w_trunc;
    logic                 w_ovf;
    logic [OUT_WIDTH-1:0] r_s1_data;
    logic                 r_s1_ovf;
`ifdef NVDLA_HLS_SHL_ROUND_EN
    logic                 w_rnd;
    logic                 r_s1_rnd;
`endif

    nv_nvdla_hls_shl_core #(
        .IN_WIDTH    (IN_WIDTH),
        .FRAC_WIDTH  (FRAC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shl_core (
        .i_data_in   (bus.data_in),
        .i_frac_in   (bus.frac_in),
        .i_shift_num (bus.shift_num),
        .o_trunc     (w_trunc),
`ifdef NVDLA_HLS_SHL_ROUND_EN
        .o_rnd       (w_rnd),
`endif
        .o_ovf       (w_ovf)
    );

    // Stage-1 valid follows the input whenever the stage may be refilled.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_rdy) begin
            r_s1_vld <= bus.in_pvld;
        end
    end

    // Stage-1 payload captured only on an accepted input beat.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_s1_data <= '0;
            r_s1_ovf  <= 1'b0;
`ifdef NVDLA_HLS_SHL_ROUND_EN
            r_s1_rnd  <= 1'b0;
`endif
        end else if (w_in_acc) begin
            r_s1_data <= w_trunc;
            r_s1_ovf  <= w_ovf;
`ifdef NVDLA_HLS_SHL_ROUND_EN
            r_s1_rnd  <= w_rnd;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rounding increment and saturation.
    // ------------------------------------------------------------------
    logic                 w_s2_sat;
    logic [OUT_WIDTH-1:0] w_s2_data;
    logic [OUT_WIDTH-1:0] r_data_out;
    logic                 r_out_sat;

`ifdef NVDLA_HLS_SHL_ROUND_EN
    // One extra bit catches the increment carrying out of OUT_WIDTH.
    logic [OUT_WIDTH:0] w_s2_sum;
    assign w_s2_sum  = {1'b0, r_s1_data} + {{OUT_WIDTH{1'b0}}, r_s1_rnd};
    assign w_s2_sat  = r_s1_ovf | w_s2_sum[OUT_WIDTH];
    assign w_s2_data = w_s2_sat ? {OUT_WIDTH{1'b1}} : w_s2_sum[OUT_WIDTH-1:0];
`else
    // Truncation: nothing is added, so only the high-bit overflow saturates.
    assign w_s2_sat  = r_s1_ovf;
    assign w_s2_data = w_s2_sat ? {OUT_WIDTH{1'b1}} : r_s1_data;
`endif

    // Stage-2 valid refills whenever the output is empty or being taken.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_s2_vld <= 1'b0;
        end else if (w_s2_rdy) begin
            r_s2_vld <= r_s1_vld;
        end
    end

    // Output payload only changes when a new beat moves in, so it holds
    // steady while the consumer stalls.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_data_out <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_s1_adv) begin
            r_data_out <= w_s2_data;
            r_out_sat  <= w_s2_sat;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.out_sat  = r_out_sat;

    // ------------------------------------------------------------------
    // Saturated-beat counter: counts delivered saturated beats, sticks at
    // its maximum, and a clear in the same cycle beats the increment.
    // ------------------------------------------------------------------
    sat_cnt_t r_sat_cnt;

    // Count saturated output handshakes.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_sat_cnt <= '0;
        end else if (bus.sat_cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (w_out_hs & r_out_sat) begin
            r_sat_cnt <= sat_cnt_inc(r_sat_cnt);
        end
    end

    assign bus.sat_cnt = r_sat_cnt;

endmodule
